// File: rtl/lcd_clk_div_gen_if.sv
// Purpose : bus bundle for lcd_clk_div_gen (divisor reload in, strobes/status out).
// Signals : DIV_IN   - per-channel divisor, channel i in [i*DIV_W +: DIV_W]
//           DIV_LOAD - per-channel one-cycle load strobe
//           CE_OUT   - per-channel one-cycle enable per divided period
//           CLK_OUT  - per-channel registered divided square wave
//           DIV_BUSY - per-channel reload pending
//           LOCK     - all channels stable long enough
interface lcd_clk_div_gen_if #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned DIV_W  = 8
) ();
   logic [NUM_CH*DIV_W-1:0] DIV_IN;
   logic [NUM_CH-1:0]       DIV_LOAD;
   logic [NUM_CH-1:0]       CE_OUT;
   logic [NUM_CH-1:0]       CLK_OUT;
   logic [NUM_CH-1:0]       DIV_BUSY;
   logic                    LOCK;

   // Timing consumer / reload controller side
   modport master (
      output DIV_IN, DIV_LOAD,
      input  CE_OUT, CLK_OUT, DIV_BUSY, LOCK
   );

   // Divider side
   modport slave (
      input  DIV_IN, DIV_LOAD,
      output CE_OUT, CLK_OUT, DIV_BUSY, LOCK
   );
endinterface

// File: rtl/lcd_clk_div_gen.sv
// Purpose : multi-channel clock-enable generator for LCD pixel/line/refresh
//           timing. Each channel divides CLKA by a run-time reloadable
//           divisor; reloads take effect only at a period boundary. A lock
//           FSM reports when all channels have been quiet for LOCK_CNT cycles.
// Ports   : CLKA   - fabric clock (GLA0), sole clock
//           RESET  - synchronous, active-high reset
//           bus_if - lcd_clk_div_gen_if.slave (DIV_IN, DIV_LOAD in;
//                    CE_OUT, CLK_OUT, DIV_BUSY, LOCK out, all registered)
module lcd_clk_div_gen #(
   parameter int unsigned NUM_CH   = 3,
   parameter int unsigned DIV_W    = 8,
   parameter int unsigned DIV_RST  = 4,
   parameter int unsigned LOCK_CNT = 16
) (
   input  logic                CLKA,
   input  logic                RESET,
   lcd_clk_div_gen_if.slave    bus_if
);

   localparam int unsigned SET_W = $clog2(LOCK_CNT + 1);

   typedef enum logic {
      ST_SETTLE = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

   logic [DIV_W-1:0]  r_cnt  [NUM_CH];
   logic [DIV_W-1:0]  r_div  [NUM_CH];
   logic [DIV_W-1:0]  r_pend [NUM_CH];
   logic [NUM_CH-1:0] r_busy;
   logic [NUM_CH-1:0] r_ce;
   logic [NUM_CH-1:0] r_clk_out;

   logic [DIV_W-1:0]  w_de   [NUM_CH];
   logic [NUM_CH-1:0] w_wrap;

   lock_state_t       r_state;
   lock_state_t       w_state_nxt;
   logic [SET_W-1:0]  r_settle;
   logic [SET_W-1:0]  w_settle_nxt;
   logic              r_lock;
   logic              w_quiet;

   // Effective divisor (0 behaves as 1) and last-count-of-period detect
   always_comb begin
      w_wrap = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_de[i]   = (r_div[i] == '0) ? DIV_W'(1) : r_div[i];
         w_wrap[i] = (r_cnt[i] == (w_de[i] - DIV_W'(1)));
      end
   end

   // Per-channel counters, reload and registered strobes
   always_ff @(posedge CLKA) begin
      if (RESET) begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_cnt[i]  <= '0;
            r_div[i]  <= DIV_W'(DIV_RST);
            r_pend[i] <= '0;
         end
         r_busy    <= '0;
         r_ce      <= '0;
         r_clk_out <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            r_ce[i]      <= w_wrap[i];
            r_clk_out[i] <= (r_cnt[i] < (w_de[i] >> 1));
            if (w_wrap[i]) begin
               r_cnt[i] <= '0;
               // Apply a pending divisor only at the boundary so the running
               // period always completes.
               if (r_busy[i]) begin
                  r_div[i]  <= r_pend[i];
                  r_busy[i] <= 1'b0;
               end
            end else begin
               r_cnt[i] <= r_cnt[i] + DIV_W'(1);
            end
            // A load in the same cycle wins over the busy clear: the old
            // pending value is applied, the new one stays pending.
            if (bus_if.DIV_LOAD[i]) begin
               r_pend[i] <= bus_if.DIV_IN[i*DIV_W +: DIV_W];
               r_busy[i] <= 1'b1;
            end
         end
      end
   end

   assign w_quiet = ~(|r_busy) & ~(|bus_if.DIV_LOAD);

   // Lock FSM state register
   always_ff @(posedge CLKA) begin
      if (RESET) begin
         r_state  <= ST_SETTLE;
         r_settle <= '0;
         r_lock   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_settle <= w_settle_nxt;
         r_lock   <= (w_state_nxt == ST_LOCKED);
      end
   end

   // Lock FSM next state
   always_comb begin
      w_state_nxt  = r_state;
      w_settle_nxt = r_settle;
      case (r_state)
         ST_SETTLE: begin
            if (!w_quiet) begin
               w_settle_nxt = '0;
            end else if (r_settle == SET_W'(LOCK_CNT - 1)) begin
               w_state_nxt  = ST_LOCKED;
               w_settle_nxt = '0;
            end else begin
               w_settle_nxt = r_settle + SET_W'(1);
            end
         end
         ST_LOCKED: begin
            if (|bus_if.DIV_LOAD) begin
               w_state_nxt  = ST_SETTLE;
               w_settle_nxt = '0;
            end
         end
         default: begin
            w_state_nxt  = ST_SETTLE;
            w_settle_nxt = '0;
         end
      endcase
   end

   assign bus_if.CE_OUT   = r_ce;
   assign bus_if.CLK_OUT  = r_clk_out;
   assign bus_if.DIV_BUSY = r_busy;
   assign bus_if.LOCK     = r_lock;

endmodule

// File: tb/tb_lcd_clk_div_gen.sv
// Purpose : self-checking bench for lcd_clk_div_gen. A timeline model tracks,
//           per channel, the cycle at which the current divisor segment began
//           and derives the expected strobes from the elapsed time modulo the
//           effective divisor; directed scenarios are followed by random loads
//           and occasional resets.
module tb_lcd_clk_div_gen;

   localparam int unsigned NUM_CH   = 3;
   localparam int unsigned DIV_W    = 8;
   localparam int unsigned DIV_RST  = 4;
   localparam int unsigned LOCK_CNT = 16;

   logic clka = 1'b0;
   logic reset;

   always #5 clka = ~clka;

   lcd_clk_div_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus_if ();

   lcd_clk_div_gen #(
      .NUM_CH  (NUM_CH),
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST),
      .LOCK_CNT(LOCK_CNT)
   ) u_dut (
      .CLKA  (clka),
      .RESET (reset),
      .bus_if(bus_if.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   longint m_cyc;
   longint m_seg  [NUM_CH];
   int     m_de   [NUM_CH];
   int     m_pend [NUM_CH];
   bit     m_busy [NUM_CH];
   bit     m_locked;
   int     m_run;
   logic [NUM_CH-1:0] e_ce, e_clk, e_busy;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, m_cyc, obs, exp);
      end
   endtask

   function automatic int eff(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   // Phase of channel ch as seen by the coming edge
   function automatic int phase(input int ch);
      return int'((m_cyc - m_seg[ch]) % longint'(m_de[ch]));
   endfunction

   function automatic logic [NUM_CH*DIV_W-1:0] mk_din(input int ch, input int val);
      logic [NUM_CH*DIV_W-1:0] d;
      d = '0;
      d[ch*DIV_W +: DIV_W] = DIV_W'(val);
      return d;
   endfunction

   task automatic model_edge(input bit r, input logic [NUM_CH-1:0] ld,
                             input logic [NUM_CH*DIV_W-1:0] din);
      bit quiet;
      int p;
      if (r) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_de[i]   = eff(DIV_RST);
            m_seg[i]  = m_cyc + 1;
            m_busy[i] = 1'b0;
            m_pend[i] = 0;
         end
         e_ce = '0; e_clk = '0; e_busy = '0;
         m_locked = 1'b0;
         m_run    = 0;
      end else begin
         quiet = (ld == '0);
         for (int i = 0; i < NUM_CH; i++) if (m_busy[i]) quiet = 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            p = phase(i);
            e_ce[i]  = (p == m_de[i] - 1);
            e_clk[i] = (p < m_de[i] / 2);
            if (p == m_de[i] - 1 && m_busy[i]) begin
               m_de[i]   = eff(m_pend[i]);
               m_seg[i]  = m_cyc + 1;
               m_busy[i] = 1'b0;
            end
            if (ld[i]) begin
               m_pend[i] = int'(din[i*DIV_W +: DIV_W]);
               m_busy[i] = 1'b1;
            end
            e_busy[i] = m_busy[i];
         end
         if (m_locked) begin
            if (ld != '0) begin
               m_locked = 1'b0;
               m_run    = 0;
            end
         end else if (quiet) begin
            m_run++;
            if (m_run == LOCK_CNT) begin
               m_locked = 1'b1;
               m_run    = 0;
            end
         end else begin
            m_run = 0;
         end
      end
   endtask

   task automatic step(input bit r, input logic [NUM_CH-1:0] ld,
                       input logic [NUM_CH*DIV_W-1:0] din);
      @(negedge clka);
      reset           = r;
      bus_if.DIV_LOAD = ld;
      bus_if.DIV_IN   = din;
      @(posedge clka);
      model_edge(r, ld, din);
      m_cyc++;
      #1;
      check("ce_out",   32'(bus_if.CE_OUT),   32'(e_ce));
      check("clk_out",  32'(bus_if.CLK_OUT),  32'(e_clk));
      check("div_busy", 32'(bus_if.DIV_BUSY), 32'(e_busy));
      check("lock",     32'(bus_if.LOCK),     32'(m_locked));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, '0, '0);
   endtask

   // Advance until channel ch is in its last count (bounded)
   task automatic to_wrap(input int ch);
      for (int k = 0; k < 300; k++) begin
         if (phase(ch) == m_de[ch] - 1) return;
         idle(1);
      end
      check("wrap_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      logic [NUM_CH-1:0]       ld;
      logic [NUM_CH*DIV_W-1:0] din;
      m_cyc           = 0;
      m_locked        = 1'b0;
      m_run           = 0;
      reset           = 1'b1;
      bus_if.DIV_LOAD = '0;
      bus_if.DIV_IN   = '0;

      // Reset release, free-running at the reset divisor, lock acquisition
      step(1'b1, '0, '0);
      step(1'b1, '0, '0);
      idle(40);

      // Channel 1 reload to 6 at cnt=1
      to_wrap(1);
      idle(2);
      step(1'b0, NUM_CH'(3'b010), mk_din(1, 6));
      idle(40);

      // Channel 2: divisor 0, then 1
      step(1'b0, NUM_CH'(3'b100), mk_din(2, 0));
      idle(15);
      step(1'b0, NUM_CH'(3'b100), mk_din(2, 1));
      idle(15);

      // Channel 0: load 7 exactly in a wrap cycle, then 3 while busy
      to_wrap(0);
      step(1'b0, NUM_CH'(3'b001), mk_din(0, 7));
      idle(1);
      step(1'b0, NUM_CH'(3'b001), mk_din(0, 3));
      idle(25);

      // Load while busy inside a wrap cycle
      step(1'b0, NUM_CH'(3'b001), mk_din(0, 5));
      to_wrap(0);
      step(1'b0, NUM_CH'(3'b001), mk_din(0, 2));
      idle(20);

      // Reset mid-period with a load pending
      step(1'b0, NUM_CH'(3'b001), mk_din(0, 9));
      idle(1);
      step(1'b1, '0, '0);
      idle(30);

      // Odd divisor 5, then 5 -> 2 reload
      step(1'b0, NUM_CH'(3'b010), mk_din(1, 5));
      idle(20);
      step(1'b0, NUM_CH'(3'b010), mk_din(1, 2));
      idle(20);

      // Random reloads and occasional resets
      for (int k = 0; k < 3000; k++) begin
         ld  = '0;
         din = '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if ($urandom_range(0, 15) == 0) begin
               ld[i] = 1'b1;
               din[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 9));
            end
         end
         if (k > 1500 && k < 1700) ld = '0;
         step(($urandom_range(0, 499) == 0), ld, din);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
